// File: rtl/snitch_pkg.sv
// Shared LSU/TCDM request and response types for the Snitch data path,
// plus the per-slot payload kept by the response reorder buffer.
package snitch_pkg;

  localparam int unsigned NumIntOutstandingLoads = 8;
  localparam int unsigned MetaIdWidth = $clog2(NumIntOutstandingLoads);

  typedef logic [31:0]            addr_t;
  typedef logic [31:0]            data_t;
  typedef logic [3:0]             strb_t;
  typedef logic [MetaIdWidth-1:0] meta_id_t;

  typedef struct packed {
    meta_id_t id;
    addr_t    addr;
    logic     write;
    data_t    data;
    strb_t    strb;
  } dreq_t;

  typedef struct packed {
    meta_id_t id;
    data_t    data;
    logic     write;
    logic     error;
  } dresp_t;

  typedef struct packed {
    data_t data;
    logic  write;
    logic  error;
  } reorder_entry_t;

endpackage

// File: rtl/snitch_dresp_reorder.sv
// Tags core data requests with a ring-slot ID and hands out-of-order memory
// responses back to the core in issue order.
module snitch_dresp_reorder
  import snitch_pkg::*;
#(
  parameter int unsigned NumOutstanding = NumIntOutstandingLoads,
  parameter int unsigned IdWidth        = MetaIdWidth
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  dreq_t  core_req_i,
  input  logic   core_req_valid_i,
  output logic   core_req_ready_o,
  output dreq_t  mem_req_o,
  output logic   mem_req_valid_o,
  input  logic   mem_req_ready_i,
  input  dresp_t mem_resp_i,
  input  logic   mem_resp_valid_i,
  output logic   mem_resp_ready_o,
  output dresp_t core_resp_o,
  output logic   core_resp_valid_o,
  input  logic   core_resp_ready_i
);

  localparam logic [IdWidth:0] PtrOne  = {{IdWidth{1'b0}}, 1'b1};
  localparam logic [IdWidth:0] FullXor = {1'b1, {IdWidth{1'b0}}};

  logic [IdWidth:0]          wr_ptr_reg, rd_ptr_reg;
  logic [NumOutstanding-1:0] pending_reg, pending_next;
  logic [NumOutstanding-1:0] done_reg, done_next;
  reorder_entry_t            slot_reg [NumOutstanding];

  logic [IdWidth-1:0] wr_idx, rd_idx, resp_idx;
  logic full, alloc, pop, resp_ok;

  assign wr_idx   = wr_ptr_reg[IdWidth-1:0];
  assign rd_idx   = rd_ptr_reg[IdWidth-1:0];
  assign resp_idx = IdWidth'(mem_resp_i.id);

  // Full depends only on registered pointers, so a pop never refills in the same cycle.
  assign full = (wr_ptr_reg ^ rd_ptr_reg) == FullXor;

  assign mem_req_valid_o  = core_req_valid_i & ~full;
  assign core_req_ready_o = mem_req_ready_i & ~full;
  assign mem_resp_ready_o = 1'b1;

  always_comb begin
    mem_req_o    = core_req_i;
    mem_req_o.id = meta_id_t'(wr_idx);
  end

  assign alloc   = core_req_valid_i & mem_req_ready_i & ~full;
  assign resp_ok = mem_resp_valid_i & pending_reg[resp_idx] & ~done_reg[resp_idx];
  assign pop     = core_resp_valid_o & core_resp_ready_i;

  assign core_resp_valid_o = done_reg[rd_idx];
  assign core_resp_o = '{id:    meta_id_t'(rd_idx),
                         data:  slot_reg[rd_idx].data,
                         write: slot_reg[rd_idx].write,
                         error: slot_reg[rd_idx].error};

  // Alloc, response and pop always hit distinct slots, so the updates never collide.
  always_comb begin
    pending_next = pending_reg;
    done_next    = done_reg;
    if (alloc) begin
      pending_next[wr_idx] = 1'b1;
      done_next[wr_idx]    = 1'b0;
    end
    if (resp_ok) begin
      done_next[resp_idx] = 1'b1;
    end
    if (pop) begin
      pending_next[rd_idx] = 1'b0;
      done_next[rd_idx]    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      pending_reg <= '0;
      done_reg    <= '0;
    end else begin
      pending_reg <= pending_next;
      done_reg    <= done_next;
      if (alloc) wr_ptr_reg <= wr_ptr_reg + PtrOne;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PtrOne;
    end
  end

  // Payload is only meaningful while done is set, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (resp_ok) begin
      slot_reg[resp_idx] <= '{data:  mem_resp_i.data,
                              write: mem_resp_i.write,
                              error: mem_resp_i.error};
    end
  end

  a_id_width: assert property (@(posedge clk_i) IdWidth == $clog2(NumOutstanding))
    else $error("snitch_dresp_reorder: IdWidth does not match NumOutstanding");
  a_pow2: assert property (@(posedge clk_i)
      (NumOutstanding >= 2) && ((NumOutstanding & (NumOutstanding - 1)) == 0))
    else $error("snitch_dresp_reorder: NumOutstanding must be a power of two >= 2");
  a_resp_ready: assert property (@(posedge clk_i) mem_resp_ready_o == 1'b1)
    else $error("snitch_dresp_reorder: mem_resp_ready_o deasserted");
  a_illegal_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
      mem_resp_valid_i |-> (pending_reg[resp_idx] && !done_reg[resp_idx]))
    else $warning("snitch_dresp_reorder: dropped response to non-pending or done id %0d",
                  resp_idx);

endmodule

// File: tb/tb_snitch_dresp_reorder.sv
// Directed bench for snitch_dresp_reorder: in-order, reversed, full, random
// wrap/backpressure, simultaneous events, reset and late responses.
module tb_snitch_dresp_reorder;
  import snitch_pkg::*;

  localparam int N = 8;

  logic   clk = 1'b0;
  logic   rst_n;
  dreq_t  core_req;
  logic   core_req_valid;
  logic   core_req_ready;
  dreq_t  mem_req;
  logic   mem_req_valid;
  logic   mem_req_ready;
  dresp_t mem_resp;
  logic   mem_resp_valid;
  logic   mem_resp_ready;
  dresp_t core_resp;
  logic   core_resp_valid;
  logic   core_resp_ready;

  int n_vec = 0;
  int n_err = 0;

  // random-stream model state
  int     issued, popped, resp_seq, ncand, pick, exp_full_i;
  logic [19:0] responded;
  logic   exp_full, head_done, m_alloc, m_pop, prev_stall;
  data_t  prev_data;

  always #5 clk = ~clk;

  snitch_dresp_reorder dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .core_req_i       (core_req),
    .core_req_valid_i (core_req_valid),
    .core_req_ready_o (core_req_ready),
    .mem_req_o        (mem_req),
    .mem_req_valid_o  (mem_req_valid),
    .mem_req_ready_i  (mem_req_ready),
    .mem_resp_i       (mem_resp),
    .mem_resp_valid_i (mem_resp_valid),
    .mem_resp_ready_o (mem_resp_ready),
    .core_resp_o      (core_resp),
    .core_resp_valid_o(core_resp_valid),
    .core_resp_ready_i(core_resp_ready)
  );

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // One accepted request; called and returns at posedge+1.
  task automatic do_req(input string tag, input int exp_id);
    core_req_valid = 1'b1;
    mem_req_ready  = 1'b1;
    core_req.addr  = 32'h1000 + 32'(exp_id);
    core_req.id    = 3'd7;
    #1;
    check_vec({tag, "_ready"}, 32'(core_req_ready), 32'd1);
    check_vec({tag, "_id"}, 32'(mem_req.id), 32'(exp_id));
    step();
    core_req_valid = 1'b0;
  endtask

  task automatic respond(input int id, input data_t data);
    mem_resp_valid = 1'b1;
    mem_resp.id    = meta_id_t'(id);
    mem_resp.data  = data;
    mem_resp.write = 1'b0;
    mem_resp.error = 1'b0;
    step();
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    core_req = '0;
    core_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    mem_resp = '0;
    mem_resp_valid = 1'b0;
    core_resp_ready = 1'b1;
    step();
    step();
    check_vec("rst_resp_valid", 32'(core_resp_valid), 32'd0);
    check_vec("rst_req_ready", 32'(core_req_ready), 32'd1);
    check_vec("rst_mem_valid", 32'(mem_req_valid), 32'd0);
    check_vec("rst_resp_ready", 32'(mem_resp_ready), 32'd1);
    rst_n = 1'b1;

    // In-order: 3 loads, 2-cycle response latency, core sees each one cycle later.
    for (int k = 0; k < 3; k++) begin
      do_req("io_req", k);
      step();
      mem_resp_valid = 1'b1;
      mem_resp.id    = meta_id_t'(k);
      mem_resp.data  = 32'hA000_0000 + 32'(k);
      mem_resp.error = 1'b0;
      #1;
      check_vec("io_no_bypass", 32'(core_resp_valid), 32'd0);
      step();
      mem_resp_valid = 1'b0;
      #1;
      check_vec("io_valid", 32'(core_resp_valid), 32'd1);
      check_vec("io_data", core_resp.data, 32'hA000_0000 + 32'(k));
      check_vec("io_id", 32'(core_resp.id), 32'(k));
      step();
      check_vec("io_empty", 32'(core_resp_valid), 32'd0);
    end

    // Reversed return: nothing visible until id 0, then 4 back-to-back pops.
    do_reset();
    for (int k = 0; k < 4; k++) do_req("rev_req", k);
    for (int k = 3; k >= 1; k--) begin
      respond(k, 32'hB000_0000 + 32'(k));
      check_vec("rev_hold", 32'(core_resp_valid), 32'd0);
    end
    respond(0, 32'hB000_0000);
    for (int k = 0; k < 4; k++) begin
      check_vec("rev_valid", 32'(core_resp_valid), 32'd1);
      check_vec("rev_data", core_resp.data, 32'hB000_0000 + 32'(k));
      step();
    end
    check_vec("rev_drained", 32'(core_resp_valid), 32'd0);

    // Full: eight outstanding block the ninth until a pop frees slot 0.
    do_reset();
    for (int k = 0; k < N; k++) do_req("full_req", k);
    core_req_valid = 1'b1;
    #1;
    check_vec("full_ready", 32'(core_req_ready), 32'd0);
    check_vec("full_mem_valid", 32'(mem_req_valid), 32'd0);
    respond(0, 32'hD000_0000);
    #1;
    check_vec("full_still", 32'(core_req_ready), 32'd0);
    check_vec("full_pop_data", core_resp.data, 32'hD000_0000);
    step();
    check_vec("full_freed_ready", 32'(core_req_ready), 32'd1);
    check_vec("full_freed_valid", 32'(mem_req_valid), 32'd1);
    check_vec("full_reuse_id", 32'(mem_req.id), 32'd0);
    step();
    core_req_valid = 1'b0;

    // Wrap and backpressure: 20 requests, random return order and core ready.
    do_reset();
    issued = 0;
    popped = 0;
    responded = '0;
    prev_stall = 1'b0;
    prev_data = '0;
    for (int cyc = 0; cyc < 600 && popped < 20; cyc++) begin
      core_req_valid = (issued < 20) && ($urandom_range(0, 3) != 0);
      core_req.addr  = 32'(issued);
      mem_req_ready  = ($urandom_range(0, 4) != 0);
      ncand = 0;
      for (int s = popped; s < issued; s++) if (!responded[s]) ncand++;
      resp_seq = -1;
      if (ncand > 0 && $urandom_range(0, 1) == 1) begin
        pick = $urandom_range(0, ncand - 1);
        for (int s = popped; s < issued; s++) begin
          if (!responded[s]) begin
            if (pick == 0 && resp_seq < 0) resp_seq = s;
            pick--;
          end
        end
      end
      mem_resp_valid = (resp_seq >= 0);
      mem_resp.id    = meta_id_t'(resp_seq % N);
      mem_resp.data  = 32'hC000_0000 + 32'(resp_seq);
      mem_resp.error = (resp_seq % 3 == 0);
      core_resp_ready = $urandom_range(0, 1) == 1;
      #1;
      exp_full_i = issued - popped;
      exp_full = (exp_full_i == N);
      check_vec("wr_req_ready", 32'(core_req_ready), 32'(mem_req_ready & ~exp_full));
      check_vec("wr_mem_valid", 32'(mem_req_valid), 32'(core_req_valid & ~exp_full));
      if (core_req_valid && !exp_full) check_vec("wr_alloc_id", 32'(mem_req.id), 32'(issued % N));
      head_done = (popped < issued) && responded[popped];
      check_vec("wr_resp_valid", 32'(core_resp_valid), 32'(head_done));
      if (head_done) begin
        check_vec("wr_order_data", core_resp.data, 32'hC000_0000 + 32'(popped));
        check_vec("wr_order_id", 32'(core_resp.id), 32'(popped % N));
        check_vec("wr_error", 32'(core_resp.error), 32'(popped % 3 == 0));
      end
      if (prev_stall) check_vec("wr_stable", core_resp.data, prev_data);
      prev_stall = head_done && !core_resp_ready;
      prev_data  = core_resp.data;
      m_alloc = core_req_valid & mem_req_ready & ~exp_full;
      m_pop   = head_done & core_resp_ready;
      step();
      if (resp_seq >= 0) responded[resp_seq] = 1'b1;
      if (m_pop) popped++;
      if (m_alloc) issued++;
    end
    mem_resp_valid = 1'b0;
    core_req_valid = 1'b0;
    check_vec("wr_all_popped", 32'(popped), 32'd20);

    // Simultaneous alloc id 5, response id 2 and pop id 1.
    do_reset();
    mem_req_ready = 1'b1;
    core_resp_ready = 1'b0;
    for (int k = 0; k < 5; k++) do_req("sim_req", k);
    respond(0, 32'hE000_0000);
    respond(1, 32'hE000_0001);
    core_resp_ready = 1'b1;
    #1;
    check_vec("sim_head0", core_resp.data, 32'hE000_0000);
    step();
    core_req_valid = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp.id    = 3'd2;
    mem_resp.data  = 32'hE000_0002;
    mem_resp.error = 1'b1;
    #1;
    check_vec("sim_alloc_id", 32'(mem_req.id), 32'd5);
    check_vec("sim_pop_data", core_resp.data, 32'hE000_0001);
    step();
    core_req_valid = 1'b0;
    mem_resp_valid = 1'b0;
    core_resp_ready = 1'b0;
    #1;
    check_vec("sim_head2_valid", 32'(core_resp_valid), 32'd1);
    check_vec("sim_head2_id", 32'(core_resp.id), 32'd2);
    check_vec("sim_head2_data", core_resp.data, 32'hE000_0002);
    check_vec("sim_head2_err", 32'(core_resp.error), 32'd1);
    step();
    do_req("sim_next", 6);

    // Reset with requests in flight, then a late response that must be dropped.
    do_reset();
    core_resp_ready = 1'b0;
    for (int k = 0; k < 4; k++) do_req("rr_req", k);
    respond(0, 32'hF000_0000);
    check_vec("rr_pre_valid", 32'(core_resp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("rr_async_valid", 32'(core_resp_valid), 32'd0);
    check_vec("rr_async_ready", 32'(core_req_ready), 32'd1);
    step();
    rst_n = 1'b1;
    respond(2, 32'hF000_0002);
    check_vec("rr_late_ignored", 32'(core_resp_valid), 32'd0);
    do_req("rr_after", 0);
    do_req("rr_after", 1);
    do_req("rr_after", 2);
    check_vec("rr_slot2_clean", 32'(core_resp_valid), 32'd0);
    respond(0, 32'hF000_0010);
    check_vec("rr_fresh_data", core_resp.data, 32'hF000_0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
